// File: rtl/stream_pop_n.sv
// Pops the first N elements of a stream into dOut, then forwards the rest of the stream to sOut.
// out_fail is set when the stream ends before N elements have arrived.
module stream_pop_n #(
  parameter int WIDTH = 8,
  parameter int N     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_fail,
  input  logic [WIDTH-1:0]   sIn,
  input  logic               sIn_valid,
  output logic               sIn_ready,
  input  logic               sIn_last,
  output logic [WIDTH-1:0]   sOut,
  output logic               sOut_valid,
  input  logic               sOut_ready,
  output logic               sOut_last,
  output logic [N*WIDTH-1:0] dOut
);
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, PASS} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      idx;
  logic               more;
  logic               fail_q;
  logic [N*WIDTH-1:0] d_q;

  assign dOut     = d_q;
  assign out_fail = fail_q;

  // All handshake outputs decode from state only, except the PASS pass-through.
  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sIn_ready  = 1'b0;
    sOut       = '0;
    sOut_valid = 1'b0;
    sOut_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = COLLECT;
      end
      COLLECT: begin
        sIn_ready = 1'b1;
        if (sIn_valid && (sIn_last || idx == LAST_IDX)) state_n = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = more ? PASS : IDLE;
      end
      PASS: begin
        sOut       = sIn;
        sOut_valid = sIn_valid;
        sOut_last  = sIn_last;
        sIn_ready  = sOut_ready;
        if (sIn_valid && sOut_ready && sIn_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      d_q    <= '0;
      fail_q <= 1'b0;
      more   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          idx    <= '0;
          d_q    <= '0;
          fail_q <= 1'b0;
          more   <= 1'b0;
        end
        COLLECT: if (sIn_valid) begin
          for (int k = 0; k < N; k++)
            if (idx == IW'(k)) d_q[k*WIDTH +: WIDTH] <= sIn;
          idx <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            more   <= !sIn_last;
            fail_q <= 1'b0;
          end else if (sIn_last) begin
            // short stream: unfilled slots keep the zeros written on request
            more   <= 1'b0;
            fail_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_pop_n.sv
// Bench for stream_pop_n: four instances (N=2,3,4,1) share inputs; sel picks which one is observed.
module tb_stream_pop_n;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int          sel;
    int          len;
    logic [7:0]  d[6];
    int          mode;
    logic [31:0] exp_d;
    logic        exp_fail;
  } vec_t;

  logic clk = 0, rst = 0;
  logic in_valid = 0, out_ready = 0, sIn_valid = 0, sIn_last = 0, sOut_ready = 0;
  logic [7:0] sIn = 0;

  logic in_ready_a[4], out_valid_a[4], out_fail_a[4], sIn_ready_a[4], sOut_valid_a[4], sOut_last_a[4];
  logic [7:0]  sOut_a[4];
  logic [15:0] d2;
  logic [23:0] d3;
  logic [31:0] d4;
  logic [7:0]  d1;

  int sel = 0;
  logic m_in_ready, m_out_valid, m_out_fail, m_sIn_ready, m_sOut_valid, m_sOut_last;
  logic [7:0]  m_sOut;
  logic [31:0] m_dout;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  stream_pop_n #(.WIDTH(8), .N(2)) u_n2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_fail(out_fail_a[0]), .sIn(sIn), .sIn_valid(sIn_valid),
    .sIn_ready(sIn_ready_a[0]), .sIn_last(sIn_last), .sOut(sOut_a[0]), .sOut_valid(sOut_valid_a[0]),
    .sOut_ready(sOut_ready), .sOut_last(sOut_last_a[0]), .dOut(d2));
  stream_pop_n #(.WIDTH(8), .N(3)) u_n3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_fail(out_fail_a[1]), .sIn(sIn), .sIn_valid(sIn_valid),
    .sIn_ready(sIn_ready_a[1]), .sIn_last(sIn_last), .sOut(sOut_a[1]), .sOut_valid(sOut_valid_a[1]),
    .sOut_ready(sOut_ready), .sOut_last(sOut_last_a[1]), .dOut(d3));
  stream_pop_n #(.WIDTH(8), .N(4)) u_n4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_fail(out_fail_a[2]), .sIn(sIn), .sIn_valid(sIn_valid),
    .sIn_ready(sIn_ready_a[2]), .sIn_last(sIn_last), .sOut(sOut_a[2]), .sOut_valid(sOut_valid_a[2]),
    .sOut_ready(sOut_ready), .sOut_last(sOut_last_a[2]), .dOut(d4));
  stream_pop_n #(.WIDTH(8), .N(1)) u_n1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[3]),
    .out_valid(out_valid_a[3]), .out_ready(out_ready), .out_fail(out_fail_a[3]), .sIn(sIn), .sIn_valid(sIn_valid),
    .sIn_ready(sIn_ready_a[3]), .sIn_last(sIn_last), .sOut(sOut_a[3]), .sOut_valid(sOut_valid_a[3]),
    .sOut_ready(sOut_ready), .sOut_last(sOut_last_a[3]), .dOut(d1));

  always_comb begin
    m_in_ready   = in_ready_a[sel];
    m_out_valid  = out_valid_a[sel];
    m_out_fail   = out_fail_a[sel];
    m_sIn_ready  = sIn_ready_a[sel];
    m_sOut_valid = sOut_valid_a[sel];
    m_sOut_last  = sOut_last_a[sel];
    m_sOut       = sOut_a[sel];
    case (sel)
      0:       m_dout = {16'h0, d2};
      1:       m_dout = {8'h0, d3};
      2:       m_dout = d4;
      default: m_dout = {24'h0, d1};
    endcase
  end

  function automatic int nval(input int s);
    case (s)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: first min(N,len) elements land in slots 0.., the rest stays zero.
  function automatic logic [31:0] model_d(input byte_q_t st, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n && k < st.size(); k++) r[k*8 +: 8] = st[k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; sIn_valid = 0; sIn_last = 0; out_ready = 0; sOut_ready = 0;
    @(negedge clk);
    rst = 0;
  endtask

  // mode 0: all ready; 1: random; 2: sIn gapped; 3: out_ready held off 3 cycles, sOut_ready toggling
  task automatic run_req(input int s, input byte_q_t st, input int mode,
                         input logic [31:0] exp_d, input logic exp_fail);
    int n, len, pos, cyc, done_cyc, emit_cyc, exp_rem;
    bit done, seen_ov, out_done, in_pass, got_last;
    byte_q_t got;
    n = nval(s); len = st.size(); pos = 0; cyc = 0; done_cyc = -1; emit_cyc = 0;
    exp_rem = (len > n) ? len - n : 0;
    done = 0; seen_ov = 0; out_done = 0; in_pass = 0; got_last = 0;
    do_reset();
    sel = s;
    in_valid = 1;
    #1 chk("idle_in_ready", m_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    while (!done && cyc < 300) begin
      case (mode)
        1:       sIn_valid = (pos < len) && ($urandom_range(0, 3) != 0);
        2:       sIn_valid = (pos < len) && (cyc % 2 == 0);
        default: sIn_valid = (pos < len);
      endcase
      sIn      = (pos < len) ? st[pos] : 8'($urandom);
      sIn_last = (pos == len - 1);
      case (mode)
        1: begin out_ready = 1'($urandom); sOut_ready = 1'($urandom); end
        3: begin out_ready = (emit_cyc >= 3); sOut_ready = 1'(cyc % 2); end
        default: begin out_ready = 1; sOut_ready = 1; end
      endcase
      #1;
      chk("busy_in_ready", m_in_ready, 0);
      if (m_out_valid) begin
        if (!seen_ov) begin
          seen_ov = 1;
          chk("emit_latency", cyc, done_cyc + 1);
          if (mode == 0) chk("collect_start", done_cyc, ((len < n) ? len : n) - 1);
        end
        chk("dout", m_dout, exp_d);
        chk("out_fail", m_out_fail, exp_fail);
        chk("emit_sin_ready", m_sIn_ready, 0);
        emit_cyc++;
      end
      if (in_pass) begin
        chk("pass_sin_ready", m_sIn_ready, sOut_ready);
        chk("pass_sout_valid", m_sOut_valid, sIn_valid);
      end else begin
        chk("sout_idle", {m_sOut_valid, m_sOut}, 0);
      end
      if (m_sOut_valid && sOut_ready) begin
        got.push_back(m_sOut);
        if (m_sOut_last) begin got_last = 1; in_pass = 0; end
      end
      if (sIn_valid && m_sIn_ready) begin
        pos++;
        if (pos == ((len < n) ? len : n) && !out_done) done_cyc = cyc;
      end
      if (m_out_valid && out_ready) begin
        out_done = 1;
        in_pass  = (exp_rem > 0);
      end
      @(posedge clk);
      cyc++;
      done = out_done && (exp_rem == 0 || got_last);
      @(negedge clk);
    end
    if (!done) chk("timeout", 0, 1);
    sIn_valid = 0; sIn_last = 0; out_ready = 0; sOut_ready = 0;
    #1;
    chk("back_idle", m_in_ready, 1);
    chk("rem_count", got.size(), exp_rem);
    for (int i = 0; i < got.size() && i < exp_rem; i++) chk("rem_data", got[i], st[n + i]);
    chk("rem_last", got_last, exp_rem > 0);
  endtask

  initial begin
    vec_t vecs[8];
    byte_q_t q;
    vecs[0] = '{0, 4, '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0}, 0, 32'h0000_0605, 1'b0};
    vecs[1] = '{1, 2, '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 32'h0000_0201, 1'b1};
    vecs[2] = '{0, 2, '{8'd9, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 32'h0000_0a09, 1'b0};
    vecs[3] = '{0, 6, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 3, 32'h0000_0201, 1'b0};
    vecs[4] = '{2, 5, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0}, 2, 32'h0403_0201, 1'b0};
    vecs[5] = '{3, 2, '{8'hAA, 8'hBB, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 32'h0000_00AA, 1'b0};
    vecs[6] = '{3, 1, '{8'h7E, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 32'h0000_007E, 1'b0};
    vecs[7] = '{2, 1, '{8'hF0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 32'h0000_00F0, 1'b1};

    do_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("rst_in_ready", m_in_ready, 1);
      chk("rst_outs", {m_out_valid, m_out_fail, m_sIn_ready, m_sOut_valid, m_sOut_last}, 0);
      chk("rst_dout", m_dout, 0);
    end

    for (int i = 0; i < 8; i++) begin
      q = {};
      for (int j = 0; j < vecs[i].len; j++) q.push_back(vecs[i].d[j]);
      run_req(vecs[i].sel, q, vecs[i].mode, vecs[i].exp_d, vecs[i].exp_fail);
    end

    // Reset in the middle of collection discards the partial element.
    do_reset();
    sel = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0; sIn = 8'h33; sIn_valid = 1; sIn_last = 0;
    @(negedge clk);
    sIn_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst_in_ready", m_in_ready, 1);
    chk("midrst_dout", m_dout, 0);
    chk("midrst_outs", {m_out_valid, m_out_fail, m_sIn_ready}, 0);
    q = {8'd20, 8'd21, 8'd22};
    run_req(0, q, 0, 32'h0000_1514, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int s, len;
      s = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      q = {};
      for (int j = 0; j < len; j++) q.push_back(8'($urandom));
      run_req(s, q, 1, model_d(q, nval(s)), len < nval(s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_pop_n.md
Name: stream_pop_n

Overview:
- Parametrised successor to the fixed two-pop stream primitive.
- Per request, pops the first N elements of an input stream into N integer outputs, then forwards the remainder of the stream to the output stream until its last beat.
- Adds explicit end-of-stream signalling and a fail result when the stream ends before N elements arrive.
- Sits between a stream producer and consumer primitives in generated dataflow graphs, using the standard sync handshake.

Parameters:
- WIDTH, 8, bit width of stream elements and integer outputs (intN).
- N, 2, elements popped per request; legal range N >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- out_valid  out  1  dOut/out_fail valid.
- out_ready  in  1  consumer accepts the result.
- out_fail  out  1  stream ended before N elements; meaningful when out_valid=1.
- sIn  in  WIDTH  input stream data.
- sIn_valid  in  1  input stream beat valid.
- sIn_ready  out  1  input stream beat accepted.
- sIn_last  in  1  beat is the final element of the stream.
- sOut  out  WIDTH  output stream data (stream remainder).
- sOut_valid  out  1  output stream beat valid.
- sOut_ready  in  1  downstream accepts the beat.
- sOut_last  out  1  final beat of the remainder.
- dOut  out  N*WIDTH  popped elements; element k occupies bits [k*WIDTH +: WIDTH], k=0 is first popped.

Behaviour:
- Transfer rule: a transfer occurs on a rising clk edge where valid && ready.
- States: IDLE, COLLECT, EMIT, PASS. State register `idx` is $clog2(N+1) bits; `more` flag (remainder exists).
- Reset (rst=1 at posedge, any state, including mid-stream): state=IDLE, idx=0, dOut=0, out_fail=0, more=0. Partial data is discarded. in_ready=1; out_valid, sIn_ready, sOut_valid, sOut_last=0.
- IDLE:
  - in_ready=1, all others inactive.
  - in_valid → COLLECT; idx=0, dOut cleared to 0, out_fail=0.
- COLLECT:
  - sIn_ready=1, in_ready=0.
  - Each sIn transfer writes slot idx and increments idx.
  - Beat with idx==N-1 and !sIn_last → EMIT, more=1.
  - Beat with idx==N-1 and sIn_last → EMIT, more=0, out_fail=0.
  - Beat with idx<N-1 and sIn_last → EMIT, more=0, out_fail=1; unfilled slots remain 0.
- EMIT:
  - out_valid=1; dOut and out_fail held stable; sIn_ready=0.
  - out_ready transfer → PASS if more, else IDLE.
  - Latency: out_valid is high the cycle after the transfer that completes collection; minimum request-to-out_valid latency is N+1 cycles with sIn_valid constantly high.
- PASS:
  - Combinational pass-through: sOut=sIn, sOut_valid=sIn_valid, sOut_last=sIn_last, sIn_ready=sOut_ready.
  - Transfer with sIn_last → IDLE.
  - dOut retains its last value; out_valid=0.
- Requests while not IDLE are not accepted (in_ready=0); in_valid must be held until accepted.
- sOut is 0 and sOut_valid=0 outside PASS.
- No combinational path from in_valid to in_ready; out_valid is registered.
- N=1 degenerates correctly: the first beat goes straight to EMIT.

Test Plan:
- N=2, WIDTH=8, in_valid=1 for one cycle, sIn beats 5,6,7,8 (last on 8), all readies=1 → out_valid the cycle after beat 6; dOut={6,5} (slot0=5), out_fail=0; sOut emits 7 then 8 with sOut_last on 8; back to IDLE.
- N=3, stream 1,2 (last on 2) → out_valid with out_fail=1, dOut slot0=1, slot1=2, slot2=0; no sOut beats; IDLE after out_ready.
- N=2, stream 9,10 with last on 10 → out_fail=0, dOut={10,9}, PASS skipped, in_ready=1 one cycle after the out transfer.
- Backpressure: out_ready=0 for 3 cycles in EMIT → out_valid and dOut stable, sIn_ready=0. Then sOut_ready toggling in PASS → sIn_ready tracks sOut_ready and no beat is lost or duplicated (check the sequence 3,4,5,6).
- Reset asserted mid-COLLECT after 1 beat → next cycle state IDLE, dOut=0, in_ready=1. A new request with stream 20,21,22(last) yields dOut={21,20}.
- Gapped input: sIn_valid low on alternate cycles, N=4, stream 1..5 → dOut slots 1,2,3,4 and sOut emits 5 with last.
